deser_queue: RTL and testbench

Parametrised serial-to-word receive path with built-in buffering. A WIDTH-bit deserializer feeds a DEPTH-entry circular FIFO, and both run from the single clock1M input.
Internal divide counters generate one-cycle clock enables. The deserializer enable defaults to a 100 kHz rate and the FIFO enable to a 10 kHz rate. No derived clocks are produced.
The block is the next-generation receive path of the top level. It adds configurable width, depth, bit order, overflow policy and occupancy/flag outputs.

---
 rtl/deser_queue.sv | 231 +++++++++++++++++++++++
 tb/tb_deser_queue.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/deser_queue.sv
// deser_queue: serial-to-word receive path. A WIDTH-bit deserializer hands
// completed words to a DEPTH-entry circular FIFO. Both halves run from
// clock1M and are paced by one-cycle clock enables from internal dividers.
//
// Optional feature macro: DESER_QUEUE_OVF_CNT_EN
//   When defined, adds ovf_count[15:0]. This saturating counter records
//   dropped words (DROP_ON_FULL=1) or FIFO ticks spent stalled (DROP_ON_FULL=0).
module deser_queue #(
    parameter int WIDTH        = 8,    // bits per word, 2..32
    parameter int DEPTH        = 8,    // FIFO entries, power of two, 2..64
    parameter int DES_DIV      = 10,   // clock1M cycles per deserializer tick
    parameter int FIFO_DIV     = 100,  // clock1M cycles per FIFO tick
    parameter int MSB_FIRST    = 1,    // 1: first bit lands in bit WIDTH-1
    parameter int DROP_ON_FULL = 0     // 1: discard pending word when full
) (
    input  logic                       clock1M,
    input  logic                       reset,
    input  logic                       data_in,
    input  logic                       write_in,
    input  logic                       dequeue_in,
    output logic [WIDTH-1:0]           data_out,
    output logic                       data_valid,
    output logic                       status_out,
    output logic [$clog2(DEPTH+1)-1:0] len_out,
    output logic                       full,
    output logic                       empty
`ifdef DESER_QUEUE_OVF_CNT_EN
    ,
    output logic [15:0]                ovf_count
`endif
);

    localparam int LEN_W   = $clog2(DEPTH + 1);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int BIT_W   = $clog2(WIDTH);
    localparam int DES_CW  = (DES_DIV  > 1) ? $clog2(DES_DIV)  : 1;
    localparam int FIFO_CW = (FIFO_DIV > 1) ? $clog2(FIFO_DIV) : 1;

    typedef enum logic {
        ST_ACCEPT  = 1'b0,
        ST_PENDING = 1'b1
    } des_state_t;

    // ------------------------------------------------------------------
    // Clock-enable generation
    // ------------------------------------------------------------------
    logic [DES_CW-1:0]  des_cnt;
    logic [FIFO_CW-1:0] fifo_cnt;
    logic               des_tick;
    logic               fifo_tick;

    assign des_tick  = (des_cnt  == DES_CW'(DES_DIV - 1));
    assign fifo_tick = (fifo_cnt == FIFO_CW'(FIFO_DIV - 1));

    // Deserializer divider: counts 0..DES_DIV-1, tick on the terminal count
    always_ff @(posedge clock1M) begin
        if (reset) begin
            des_cnt <= '0;
        end else if (des_tick) begin
            des_cnt <= '0;
        end else begin
            des_cnt <= des_cnt + DES_CW'(1);
        end
    end

    // FIFO divider: counts 0..FIFO_DIV-1, tick on the terminal count
    always_ff @(posedge clock1M) begin
        if (reset) begin
            fifo_cnt <= '0;
        end else if (fifo_tick) begin
            fifo_cnt <= '0;
        end else begin
            fifo_cnt <= fifo_cnt + FIFO_CW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Deserializer control
    // ------------------------------------------------------------------
    des_state_t       state;
    des_state_t       state_next;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] shift_next;
    logic [WIDTH-1:0] pend_word;
    logic [BIT_W-1:0] bit_cnt;
    logic             capture;    // accept data_in this cycle
    logic             word_done;  // this capture completes the word
    logic             pop;        // FIFO read granted this cycle
    logic             push;       // pending word enters the FIFO this cycle
    logic             drop;       // pending word discarded this cycle
    logic [LEN_W-1:0] len_next;

    // State register for the ACCEPT/PENDING deserializer
    always_ff @(posedge clock1M) begin
        if (reset) begin
            state <= ST_ACCEPT;
        end else begin
            state <= state_next;
        end
    end

    // Next state, capture/hand-off strobes and FIFO grant decisions
    always_comb begin
        // NOTE: combinational blocks use blocking assignments, and every output gets a default first, so no latch is inferred.
        state_next = state;
        capture    = 1'b0;
        word_done  = 1'b0;
        push       = 1'b0;
        drop       = 1'b0;
        shift_next = (MSB_FIRST != 0) ? {shift_reg[WIDTH-2:0], data_in}
                                      : {data_in, shift_reg[WIDTH-1:1]};
        // The pop decision comes first so a full FIFO can accept the pending word in the same tick.
        pop        = fifo_tick && dequeue_in && !empty;

        case (state)
            ST_ACCEPT: begin
                if (des_tick && write_in) begin
                    capture = 1'b1;
                    if (bit_cnt == BIT_W'(WIDTH - 1)) begin
                        word_done  = 1'b1;
                        state_next = ST_PENDING;
                    end
                end
            end
            ST_PENDING: begin
                if (fifo_tick) begin
                    if (!full || pop) begin
                        push       = 1'b1;
                        state_next = ST_ACCEPT;
                    end else if (DROP_ON_FULL != 0) begin
                        drop       = 1'b1;
                        state_next = ST_ACCEPT;
                    end
                end
            end
            default: state_next = ST_ACCEPT;
        endcase
    end

    assign status_out = (state == ST_ACCEPT);

    // Shift register, bit counter and the word held while it waits for the FIFO
    always_ff @(posedge clock1M) begin
        if (reset) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
            pend_word <= '0;
        end else if (capture) begin
            if (word_done) begin
                pend_word <= shift_next;
                shift_reg <= '0;
                bit_cnt   <= '0;
            end else begin
                shift_reg <= shift_next;
                bit_cnt   <= bit_cnt + BIT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Circular FIFO
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    // Occupancy after this cycle's push and pop
    always_comb begin
        len_next = len_out;
        case ({push, pop})
            2'b10:   len_next = len_out + LEN_W'(1);
            2'b01:   len_next = len_out - LEN_W'(1);
            default: len_next = len_out;
        endcase
    end

    // Storage write. When the FIFO is full and both push and pop occur, the
    // slot being read is overwritten only after the old entry has been read.
    always_ff @(posedge clock1M) begin
        // NOTE: the storage array has no reset. The pointers and len_out decide which entries are valid, and leaving the reset out lets it map onto RAM.
        if (push) begin
            mem[wr_ptr] <= pend_word;
        end
    end

    // Pointers, read port and registered occupancy flags
    always_ff @(posedge clock1M) begin
        if (reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            len_out    <= '0;
            full       <= 1'b0;
            empty      <= 1'b1;
            data_out   <= '0;
            data_valid <= 1'b0;
        end else begin
            data_valid <= pop;
            if (pop) begin
                data_out <= mem[rd_ptr];
                rd_ptr   <= rd_ptr + PTR_W'(1);
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            len_out <= len_next;
            full    <= (len_next == LEN_W'(DEPTH));
            empty   <= (len_next == '0);
        end
    end

`ifdef DESER_QUEUE_OVF_CNT_EN
    // The pending word meets a full FIFO with no pop on a FIFO tick. With
    // DROP_ON_FULL=1 this is a discard; with DROP_ON_FULL=0 it is a stall.
    logic ovf_event;
    assign ovf_event = (state == ST_PENDING) && fifo_tick && full && !pop;

    // Saturating overflow/stall counter
    always_ff @(posedge clock1M) begin
        if (reset) begin
            ovf_count <= '0;
        end else if (ovf_event && (ovf_count != 16'hFFFF)) begin
            ovf_count <= ovf_count + 16'd1;
        end
    end
`endif

    // Keeps the otherwise unread discard strobe visible in lint
    logic unused_drop;
    assign unused_drop = drop;

endmodule

// File: tb/tb_deser_queue.sv
// Testbench for deser_queue. Two instances are driven from one set of
// inputs:
//   cfg0: defaults (WIDTH 8, DEPTH 8, /10, /100, MSB first, backpressure)
//   cfg1: WIDTH 5, DEPTH 4, DES_DIV 1, FIFO_DIV 7, LSB first, drop on full
// Each instance has a queue-based reference model. A directed phase with
// literal expectations on cfg0 comes first, followed by a randomized phase.
`timescale 1ns/1ps
module tb_deser_queue;

    logic clock1M = 1'b0;
    logic reset;
    logic data_in;
    logic write_in;
    logic dequeue_in;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;  // non-reset edges since the last reset edge

    always #5 clock1M = ~clock1M;

    always @(posedge clock1M) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_cfg
        localparam int W    = (g == 0) ? 8   : 5;
        localparam int D    = (g == 0) ? 8   : 4;
        localparam int DD   = (g == 0) ? 10  : 1;
        localparam int FD   = (g == 0) ? 100 : 7;
        localparam int MSB  = (g == 0) ? 1   : 0;
        localparam int DROP = (g == 0) ? 0   : 1;
        localparam int LW   = $clog2(D + 1);

        logic [W-1:0]  data_out;
        logic          data_valid;
        logic          status_out;
        logic [LW-1:0] len_out;
        logic          full;
        logic          empty;
`ifdef DESER_QUEUE_OVF_CNT_EN
        logic [15:0]   ovf_count;
`endif

        deser_queue #(
            .WIDTH(W), .DEPTH(D), .DES_DIV(DD), .FIFO_DIV(FD),
            .MSB_FIRST(MSB), .DROP_ON_FULL(DROP)
        ) u_dut (
            .clock1M(clock1M),
            .reset(reset),
            .data_in(data_in),
            .write_in(write_in),
            .dequeue_in(dequeue_in),
            .data_out(data_out),
            .data_valid(data_valid),
            .status_out(status_out),
            .len_out(len_out),
            .full(full),
            .empty(empty)
`ifdef DESER_QUEUE_OVF_CNT_EN
            ,
            .ovf_count(ovf_count)
`endif
        );

        // Reference model: edge k after reset carries a tick when k % DIV == 0.
        int          m_k;
        int          m_nb;
        logic [31:0] m_acc;
        bit          m_pend;
        logic [31:0] m_word;
        logic [31:0] m_q[$];
        logic [31:0] m_dout;
        bit          m_dv;
        int          m_ovf;
        bit          m_live = 1'b0;
        string       pfx;

        initial pfx = (g == 0) ? "cfg0" : "cfg1";

        always @(posedge clock1M) begin
            bit des_t;
            bit fifo_t;
            bit pend_before;
            if (reset) begin
                m_k    = 0;
                m_nb   = 0;
                m_acc  = 0;
                m_pend = 0;
                m_word = 0;
                m_q.delete();
                m_dout = 0;
                m_dv   = 0;
                m_ovf  = 0;
                m_live = 1;
            end else begin
                m_k++;
                des_t       = (m_k % DD) == 0;
                fifo_t      = (m_k % FD) == 0;
                pend_before = m_pend;
                m_dv        = 0;
                if (fifo_t) begin
                    if (dequeue_in && m_q.size() > 0) begin
                        m_dout = m_q.pop_front();
                        m_dv   = 1;
                    end
                    if (m_pend) begin
                        if (m_q.size() < D) begin
                            m_q.push_back(m_word);
                            m_pend = 0;
                        end else begin
                            if (m_ovf < 65535) m_ovf++;
                            if (DROP != 0) m_pend = 0;
                        end
                    end
                end
                if (des_t && !pend_before && write_in) begin
                    m_acc = m_acc | (32'(data_in) << ((MSB != 0) ? (W - 1 - m_nb) : m_nb));
                    m_nb++;
                    if (m_nb == W) begin
                        m_word = m_acc;
                        m_acc  = 0;
                        m_nb   = 0;
                        m_pend = 1;
                    end
                end
            end
        end

        // Compare the DUT against the model once per cycle, away from the active edge
        always @(negedge clock1M) begin
            if (m_live) begin
                check({pfx, " data_out"},   32'(data_out),   m_dout);
                check({pfx, " data_valid"}, 32'(data_valid), 32'(m_dv));
                check({pfx, " status_out"}, 32'(status_out), 32'(!m_pend));
                check({pfx, " len_out"},    32'(len_out),    32'(m_q.size()));
                check({pfx, " full"},       32'(full),       32'(m_q.size() == D));
                check({pfx, " empty"},      32'(empty),      32'(m_q.size() == 0));
`ifdef DESER_QUEUE_OVF_CNT_EN
                check({pfx, " ovf_count"},  32'(ovf_count),  32'(m_ovf));
`endif
            end
        end
    end

    // Wait at negedges until cyc reaches n; an expired bound counts as a failure
    task automatic wait_cyc(input int n);
        int guard = 0;
        while (cyc < n && guard < 5000) begin
            @(negedge clock1M);
            guard++;
        end
        check("wait_cyc bound", 32'(cyc >= n), 32'd1);
    endtask

    // Send nbits of s (s[7] first), each held for one cfg0 deserializer period
    task automatic send_stream(input logic [7:0] s, input int nbits);
        write_in = 1'b1;
        for (int j = 0; j < nbits; j++) begin
            data_in = s[7-j];
            repeat (10) @(negedge clock1M);
        end
        write_in = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " data_out"},   32'(g_cfg[0].data_out),   32'h0);
        check({tag, " data_valid"}, 32'(g_cfg[0].data_valid), 32'h0);
        check({tag, " status_out"}, 32'(g_cfg[0].status_out), 32'h1);
        check({tag, " len_out"},    32'(g_cfg[0].len_out),    32'h0);
        check({tag, " full"},       32'(g_cfg[0].full),       32'h0);
        check({tag, " empty"},      32'(g_cfg[0].empty),      32'h1);
    endtask

    initial begin
        int deq_pct;
        reset      = 1'b1;
        data_in    = 1'b0;
        write_in   = 1'b0;
        dequeue_in = 1'b0;
        repeat (3) @(negedge clock1M);
        check_reset_values("reset");

        // One word 1,0,1,0,0,1,0,1 then pop it
        reset = 1'b0;
        send_stream(8'hA5, 8);
        check("t1 status after 8 bits", 32'(g_cfg[0].status_out), 32'h0);
        check("t1 len before fifo tick", 32'(g_cfg[0].len_out), 32'h0);
        wait_cyc(100);
        check("t1 len after fifo tick", 32'(g_cfg[0].len_out), 32'h1);
        check("t1 status after enqueue", 32'(g_cfg[0].status_out), 32'h1);
        dequeue_in = 1'b1;
        wait_cyc(200);
        check("t1 data_out", 32'(g_cfg[0].data_out), 32'hA5);
        check("t1 data_valid", 32'(g_cfg[0].data_valid), 32'h1);
        dequeue_in = 1'b0;
        wait_cyc(201);
        check("t1 data_valid pulse end", 32'(g_cfg[0].data_valid), 32'h0);
        check("t1 empty", 32'(g_cfg[0].empty), 32'h1);

        // Dequeue while empty
        dequeue_in = 1'b1;
        wait_cyc(300);
        check("t5 empty deq valid", 32'(g_cfg[0].data_valid), 32'h0);
        check("t5 empty deq data", 32'(g_cfg[0].data_out), 32'hA5);
        dequeue_in = 1'b0;

        // Backpressure: nine words into eight entries
        for (int w = 1; w <= 9; w++) begin
            send_stream(8'(8'h10 + w), 8);
            wait_cyc(300 + 100 * w);
        end
        wait_cyc(1200);
        check("t3 len full", 32'(g_cfg[0].len_out), 32'h8);
        check("t3 full flag", 32'(g_cfg[0].full), 32'h1);
        check("t3 status pending", 32'(g_cfg[0].status_out), 32'h0);
        dequeue_in = 1'b1;
        for (int w = 1; w <= 9; w++) begin
            wait_cyc(1200 + 100 * w);
            check("t3 pop order", 32'(g_cfg[0].data_out), 32'(8'h10 + w));
            if (w == 1) begin
                check("t3 len held at push+pop", 32'(g_cfg[0].len_out), 32'h8);
                check("t3 status after push", 32'(g_cfg[0].status_out), 32'h1);
            end
        end
        dequeue_in = 1'b0;

        // First enqueue coincides with a dequeue on an empty FIFO
        send_stream(8'h5A, 8);
        dequeue_in = 1'b1;
        wait_cyc(2200);
        check("t5 push+pop empty len", 32'(g_cfg[0].len_out), 32'h1);
        check("t5 push+pop empty valid", 32'(g_cfg[0].data_valid), 32'h0);
        wait_cyc(2300);
        check("t5 later pop", 32'(g_cfg[0].data_out), 32'h5A);
        dequeue_in = 1'b0;

        // Reset after 5 of 8 bits, then a clean 8'h3C
        send_stream(8'hFF, 5);
        reset = 1'b1;
        @(negedge clock1M);
        check_reset_values("t6 reset");
        reset = 1'b0;
        send_stream(8'h3C, 8);
        dequeue_in = 1'b1;
        wait_cyc(200);
        check("t6 word after reset", 32'(g_cfg[0].data_out), 32'h3C);
        check("t6 valid after reset", 32'(g_cfg[0].data_valid), 32'h1);
        dequeue_in = 1'b0;

        // Randomized traffic, with occasional resets and varying pop pressure
        deq_pct = 0;
        for (int i = 0; i < 30000; i++) begin
            if (i % 3000 == 0) deq_pct = $urandom_range(0, 100);
            data_in    = 1'($urandom_range(0, 1));
            write_in   = ($urandom_range(0, 9) < 8);
            dequeue_in = ($urandom_range(0, 99) < deq_pct);
            reset      = ($urandom_range(0, 3999) == 0);
            @(negedge clock1M);
        end
        reset      = 1'b0;
        write_in   = 1'b0;
        dequeue_in = 1'b0;
        repeat (5) @(negedge clock1M);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
